// File: rtl/bram_bit_streamer.sv
// Reads NUM_WORDS words from a synchronous BRAM and emits them MSB-first, one bit
// per internal tick, as the serial input and enable strobe of the pattern detector.
//
// state | meaning
// IDLE  | waiting for start
// RD    | issue one-cycle BRAM read at bram_addr
// LOAD  | wait out BRAM latency, then capture the word into the shift register
// RUN   | emit one bit per tick
// DONE  | one-cycle done pulse, drop busy
module bram_bit_streamer #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int BIT_RATE_HZ = 1,
  parameter int WORD_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int NUM_WORDS   = 16
) (
  input  logic              clock_100Mhz,
  input  logic              reset,
  input  logic              start,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [WORD_W-1:0] bram_dout,
  output logic              serial_bit,
  output logic              one_second_enable,
  output logic              busy,
  output logic              done,
  output logic [15:0]       bits_sent
);

  localparam int TICK_DIV = CLK_HZ / BIT_RATE_HZ;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_WORDS - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] LOAD = 3'd2;
  localparam logic [2:0] RUN  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  tick_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [WORD_W-1:0] shift_reg;
  logic              tick;

  assign tick = busy && (tick_cnt == TICK_LAST);

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state             <= IDLE;
      tick_cnt          <= '0;
      bit_idx           <= '0;
      shift_reg         <= '0;
      bram_en           <= 1'b0;
      bram_addr         <= '0;
      serial_bit        <= 1'b0;
      one_second_enable <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      bits_sent         <= '0;
    end else begin
      one_second_enable <= 1'b0;
      done              <= 1'b0;
      bram_en           <= 1'b0;

      // Free-running through RD/LOAD so bit spacing stays exact across words
      if (busy) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            bits_sent <= '0;
            bram_addr <= '0;
            tick_cnt  <= '0;
            state     <= RD;
          end
        end
        RD: begin
          bram_en <= 1'b1;
          state   <= LOAD;
        end
        LOAD: begin
          // First LOAD cycle is the BRAM access; data is valid on the second
          if (!bram_en) begin
            shift_reg <= bram_dout;
            bit_idx   <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (tick) begin
            serial_bit        <= shift_reg[WORD_W-1];
            one_second_enable <= 1'b1;
            shift_reg         <= shift_reg << 1;
            if (bits_sent != 16'hFFFF) bits_sent <= bits_sent + 16'd1;
            if (bit_idx == IDX_LAST) begin
              if (bram_addr == ADDR_LAST) begin
                state <= DONE;
              end else begin
                bram_addr <= bram_addr + 1'b1;
                state     <= RD;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_bit_streamer.sv
// Directed bench for bram_bit_streamer: TICK_DIV=4, two 8-bit words, 1-cycle BRAM.
module tb_bram_bit_streamer;

  logic       clock_100Mhz = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       bram_en;
  logic [3:0] bram_addr;
  logic [7:0] bram_dout = 8'h00;
  logic       serial_bit;
  logic       one_second_enable;
  logic       busy;
  logic       done;
  logic [15:0] bits_sent;

  bram_bit_streamer #(
    .CLK_HZ(4), .BIT_RATE_HZ(1), .WORD_W(8), .ADDR_W(4), .NUM_WORDS(2)
  ) dut (
    .clock_100Mhz(clock_100Mhz),
    .reset(reset),
    .start(start),
    .bram_en(bram_en),
    .bram_addr(bram_addr),
    .bram_dout(bram_dout),
    .serial_bit(serial_bit),
    .one_second_enable(one_second_enable),
    .busy(busy),
    .done(done),
    .bits_sent(bits_sent)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  logic [7:0] mem [0:15];
  always @(posedge clock_100Mhz) if (bram_en) bram_dout <= mem[bram_addr];

  typedef struct { int cyc; logic b; } exp_t;
  exp_t vec [16];

  int edge_n = 0;
  int base = 0;
  bit mon_on = 0;
  int strobe_c[$]; logic strobe_b[$];
  int en_c[$];     int en_a[$];
  int done_c[$];   int done_bits[$];
  int passed = 0;
  int total = 0;

  always @(posedge clock_100Mhz) edge_n <= edge_n + 1;

  always @(negedge clock_100Mhz) if (mon_on) begin
    if (one_second_enable) begin strobe_c.push_back(edge_n - base); strobe_b.push_back(serial_bit); end
    if (bram_en) begin en_c.push_back(edge_n - base); en_a.push_back(int'(bram_addr)); end
    if (done) begin done_c.push_back(edge_n - base); done_bits.push_back(int'(bits_sent)); end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, " bram_en"}, int'(bram_en), 0);
    chk({nm, " bram_addr"}, int'(bram_addr), 0);
    chk({nm, " bit"}, int'(serial_bit), 0);
    chk({nm, " strobe"}, int'(one_second_enable), 0);
    chk({nm, " busy"}, int'(busy), 0);
    chk({nm, " done"}, int'(done), 0);
    chk({nm, " bits_sent"}, int'(bits_sent), 0);
  endtask

  // Edge 0 is the edge that samples start; inputs change #1 after each edge.
  task automatic do_run(input int poke_at, input int rst_at, input bit hold, input int n_edges);
    strobe_c.delete(); strobe_b.delete(); en_c.delete(); en_a.delete();
    done_c.delete(); done_bits.delete();
    start = 1'b1;
    @(posedge clock_100Mhz); #1;
    base = edge_n;
    mon_on = 1;
    start = hold;
    for (int k = 1; k <= n_edges; k++) begin
      start = hold || (k == poke_at);
      reset = (k == rst_at);
      @(posedge clock_100Mhz); #1;
      if (k == rst_at) chk_idle_zero("reset mid-run");
      if (hold && k == 66) chk("restart bits_sent", int'(bits_sent), 0);
      if (hold && k == 70) chk("restart first count", int'(bits_sent), 1);
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clock_100Mhz);
    mon_on = 0;
  endtask

  task automatic check_single(input string nm);
    chk({nm, " strobe count"}, strobe_c.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < strobe_c.size()) begin
        chk($sformatf("%s strobe%0d cycle", nm, i), strobe_c[i], vec[i].cyc);
        chk($sformatf("%s strobe%0d bit", nm, i), int'(strobe_b[i]), int'(vec[i].b));
      end
    end
    chk({nm, " bram_en count"}, en_c.size(), 2);
    if (en_c.size() >= 2) begin
      chk({nm, " en0 cycle"}, en_c[0], 1);
      chk({nm, " en0 addr"}, en_a[0], 0);
      chk({nm, " en1 cycle"}, en_c[1], 33);
      chk({nm, " en1 addr"}, en_a[1], 1);
    end
    if (strobe_c.size() >= 9) chk({nm, " word gap"}, strobe_c[8] - strobe_c[7], 4);
    chk({nm, " done count"}, done_c.size(), 1);
    if (done_c.size() >= 1) begin
      chk({nm, " done cycle"}, done_c[0], 65);
      chk({nm, " bits_sent"}, done_bits[0], 16);
    end
    chk({nm, " bit held"}, int'(serial_bit), 1);
    chk({nm, " busy after"}, int'(busy), 0);
  endtask

  initial begin
    logic [15:0] pattern;
    pattern = 16'hB60D;
    for (int i = 0; i < 16; i++) begin
      vec[i].cyc = 4 + 4 * i;
      vec[i].b   = pattern[15 - i];
    end
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'hB6;
    mem[1] = 8'h0D;

    repeat (3) @(posedge clock_100Mhz);
    #1 reset = 1'b0;
    chk_idle_zero("after reset");

    do_run(0, 0, 1'b0, 80);
    check_single("single");

    do_run(10, 0, 1'b0, 80);
    check_single("busy start");

    do_run(0, 20, 1'b0, 40);
    chk("reset no done", done_c.size(), 0);
    chk("reset strobes", strobe_c.size(), 4);

    do_run(0, 0, 1'b0, 80);
    check_single("replay");

    do_run(0, 0, 1'b1, 71);
    chk("b2b done count", done_c.size(), 1);
    chk("b2b strobe count", strobe_c.size(), 17);
    if (strobe_c.size() >= 17) begin
      chk("b2b second first cycle", strobe_c[16], 70);
      chk("b2b second first bit", int'(strobe_b[16]), 1);
    end
    chk("b2b busy", int'(busy), 1);

    reset = 1'b1;
    @(posedge clock_100Mhz); #1;
    reset = 1'b0;
    chk_idle_zero("final reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
